// File: rtl/ui_uart_tx_arb_if.sv
// Handshake bundle between message sources, the arbiter and the UART
// transmitter char interface.
interface ui_uart_tx_arb_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_val;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_rdy;
    logic                 tx_data_val;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic                 grant_val;
    logic [IDX_W-1:0]     grant_idx;
    logic                 timeout_pulse;

    modport master (
        output req_val, req_data, req_last, tx_done,
        input  req_rdy, tx_data_val, tx_data,
        input  grant_val, grant_idx, timeout_pulse
    );

    modport slave (
        input  req_val, req_data, req_last, tx_done,
        output req_rdy, tx_data_val, tx_data,
        output grant_val, grant_idx, timeout_pulse
    );
endinterface

// File: rtl/ui_uart_tx_arb.sv
// Round-robin, message-granular arbiter sharing one UART transmitter
// among several byte sources, with a one-byte holding register.
module ui_uart_tx_arb #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic           clk,
    input  logic           rst_n,
    ui_uart_tx_arb_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 2);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] sel, g_inc;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       hold_q, hold_d;
    logic             g_val, g_last, g_rdy;
    logic [7:0]       g_data;
    logic             accept, wd_fire, found;
    int               pick_k;

    assign g_val  = bus.req_val[grant_q];
    assign g_last = bus.req_last[grant_q];
    assign g_data = bus.req_data[{grant_q, 3'b000} +: 8];
    assign g_inc  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // first requester at or above rr_q, wrapping
    always_comb begin
        sel    = rr_q;
        found  = 1'b0;
        pick_k = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_k = (int'(rr_q) + i) % NUM_REQ;
            if (!found && bus.req_val[pick_k]) begin
                sel   = IDX_W'(pick_k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        wd_d        = wd_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        bus.req_rdy = '0;
        g_rdy       = 1'b0;
        accept      = 1'b0;
        wd_fire     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_val) begin
                    state_d = LOCK;
                    grant_d = sel;
                    wd_d    = '0;
                end
            end
            LOCK: begin
                g_rdy                = !hold_full_q || bus.tx_done;
                bus.req_rdy[grant_q] = g_rdy;
                accept               = g_val && g_rdy;
                wd_fire = (TIMEOUT_CYC > 0) && !g_val &&
                          (wd_q == WD_W'(TIMEOUT_CYC - 1));
                if (accept)
                    wd_d = '0;
                else if (!g_val && wd_q != '1)
                    wd_d = wd_q + 1'b1;
                if ((accept && g_last) || wd_fire) begin
                    state_d = IDLE;
                    rr_d    = g_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        // a refill in the pop cycle keeps the register full with no gap
        if (accept) begin
            hold_full_d = 1'b1;
            hold_d      = g_data;
        end else if (bus.tx_done) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            grant_q     <= '0;
            wd_q        <= '0;
            hold_full_q <= 1'b0;
            hold_q      <= 8'h00;
        end else begin
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            wd_q        <= wd_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
        end
    end

    assign bus.tx_data_val   = hold_full_q;
    assign bus.tx_data       = hold_q;
    assign bus.grant_val     = (state_q == LOCK);
    assign bus.grant_idx     = grant_q;
    assign bus.timeout_pulse = wd_fire;
endmodule

// File: tb/tb_ui_uart_tx_arb.sv
// Directed bench for ui_uart_tx_arb: grant order, byte order, watchdog,
// pop/refill overlap and mid-message reset.
module tb_ui_uart_tx_arb;
    localparam int NUM_REQ = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic man_done = 1'b0;
    logic model_done = 1'b0;
    logic model_en = 1'b0;
    int   pop_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    logic [8:0] msgq [NUM_REQ][$];
    logic [7:0] popped [$];
    int         grants [$];

    ui_uart_tx_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    ui_uart_tx_arb #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.tx_done = man_done | model_done;

    // transmitter stand-in: pops each byte 10 cycles after it turns valid
    always @(negedge clk) begin
        if (model_done) begin
            model_done = 1'b0;
        end else if (model_en && bus.tx_data_val) begin
            pop_cnt++;
            if (pop_cnt == 10) begin
                model_done = 1'b1;
                popped.push_back(bus.tx_data);
                pop_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NUM_REQ; i++)
            if (msgq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_src();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (msgq[i].size() != 0) begin
                bus.req_val[i]        = 1'b1;
                bus.req_data[8*i +: 8] = msgq[i][0][7:0];
                bus.req_last[i]       = msgq[i][0][8];
            end else begin
                bus.req_val[i]  = 1'b0;
                bus.req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic run_msgs(input int n, input int max_cyc);
        logic prev_gv;
        logic [NUM_REQ-1:0] acc;
        int cyc;
        prev_gv = 1'b0;
        cyc = 0;
        drive_src();
        while (!(all_empty() && popped.size() >= n && !bus.tx_data_val)
               && cyc < max_cyc) begin
            @(negedge clk);
            #1;
            acc = bus.req_rdy & bus.req_val;
            if (bus.grant_val && !prev_gv)
                grants.push_back(int'(bus.grant_idx));
            prev_gv = bus.grant_val;
            tick();
            for (int i = 0; i < NUM_REQ; i++)
                if (acc[i]) void'(msgq[i].pop_front());
            drive_src();
            cyc++;
        end
        chk("run_bound", 32'(cyc < max_cyc), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        bus.req_val  = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        tick();
        tick();
        chk("rst_txval", 32'(bus.tx_data_val), 32'd0);
        chk("rst_gval", 32'(bus.grant_val), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_rdy", 32'(bus.req_rdy), 32'd0);
        chk("rst_txdata", 32'(bus.tx_data), 32'h00);
        chk("rst_gidx", 32'(bus.grant_idx), 32'd0);
        chk("rst_to", 32'(bus.timeout_pulse), 32'd0);

        // single-byte message from requester 2
        bus.req_val  = 4'b0100;
        bus.req_data[23:16] = 8'h41;
        bus.req_last = 4'b0100;
        tick();
        chk("t1_gval", 32'(bus.grant_val), 32'd1);
        chk("t1_gidx", 32'(bus.grant_idx), 32'd2);
        chk("t1_rdy", 32'(bus.req_rdy), 32'b0100);
        tick();
        bus.req_val  = '0;
        bus.req_last = '0;
        chk("t1_txval", 32'(bus.tx_data_val), 32'd1);
        chk("t1_txdata", 32'(bus.tx_data), 32'h41);
        chk("t1_gdrop", 32'(bus.grant_val), 32'd0);
        chk("t1_rr", 32'(dut.rr_q), 32'd3);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("t1_pop", 32'(bus.tx_data_val), 32'd0);

        // two concurrent 3-byte messages
        model_en = 1'b1;
        popped.delete();
        grants.delete();
        msgq[0] = '{9'h041, 9'h042, 9'h143};
        msgq[1] = '{9'h078, 9'h079, 9'h17a};
        run_msgs(6, 400);
        chk("t2_a", 32'(popped[0]), 32'h41);
        chk("t2_b", 32'(popped[1]), 32'h42);
        chk("t2_c", 32'(popped[2]), 32'h43);
        chk("t2_x", 32'(popped[3]), 32'h78);
        chk("t2_y", 32'(popped[4]), 32'h79);
        chk("t2_z", 32'(popped[5]), 32'h7a);
        chk("t2_ngr", 32'(grants.size()), 32'd2);
        chk("t2_g0", 32'(grants[0]), 32'd0);
        chk("t2_g1", 32'(grants[1]), 32'd1);

        // all four hold requests continuously, two 1-byte messages each
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        popped.delete();
        grants.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            msgq[i].push_back(9'h100 + 9'(i * 16));
            msgq[i].push_back(9'h101 + 9'(i * 16));
        end
        run_msgs(8, 800);
        chk("t3_ngr", 32'(grants.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("t3_gord", 32'(grants[k]), 32'(k % 4));
            chk("t3_byte", 32'(popped[k]), 32'((k % 4) * 16 + k / 4));
        end
        model_en = 1'b0;

        // watchdog: requester 1 stalls after one non-last byte
        bus.req_val  = 4'b0010;
        bus.req_data[15:8] = 8'h55;
        bus.req_last = 4'b0000;
        tick();
        chk("t4_gidx", 32'(bus.grant_idx), 32'd1);
        chk("t4_rdy", 32'(bus.req_rdy), 32'b0010);
        tick();
        bus.req_val  = 4'b0100;
        bus.req_data[23:16] = 8'h66;
        bus.req_last = 4'b0100;
        chk("t4_txdata", 32'(bus.tx_data), 32'h55);
        for (int s = 1; s < 8; s++) begin
            chk("t4_noto", 32'(bus.timeout_pulse), 32'd0);
            tick();
        end
        chk("t4_to", 32'(bus.timeout_pulse), 32'd1);
        chk("t4_gheld", 32'(bus.grant_val), 32'd1);
        tick();
        chk("t4_gdrop", 32'(bus.grant_val), 32'd0);
        chk("t4_tolow", 32'(bus.timeout_pulse), 32'd0);
        chk("t4_kept", 32'(bus.tx_data_val), 32'd1);
        chk("t4_rr", 32'(dut.rr_q), 32'd2);
        tick();
        chk("t4_g2", 32'(bus.grant_idx), 32'd2);
        chk("t4_rdyfull", 32'(bus.req_rdy), 32'b0000);

        // pop and refill in the same cycle
        man_done = 1'b1;
        #1;
        chk("t5_rdy", 32'(bus.req_rdy), 32'b0100);
        tick();
        man_done = 1'b0;
        bus.req_val  = '0;
        bus.req_last = '0;
        chk("t5_txval", 32'(bus.tx_data_val), 32'd1);
        chk("t5_txdata", 32'(bus.tx_data), 32'h66);
        chk("t5_gdrop", 32'(bus.grant_val), 32'd0);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("t5_empty", 32'(bus.tx_data_val), 32'd0);

        // reset in the middle of a message with the holding register full
        bus.req_val  = 4'b0001;
        bus.req_data[7:0] = 8'h77;
        tick();
        tick();
        bus.req_data[7:0] = 8'h78;
        chk("t6_full", 32'(bus.tx_data_val), 32'd1);
        chk("t6_gval", 32'(bus.grant_val), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_txval", 32'(bus.tx_data_val), 32'd0);
        chk("t6_txdata", 32'(bus.tx_data), 32'h00);
        chk("t6_gval0", 32'(bus.grant_val), 32'd0);
        chk("t6_gidx", 32'(bus.grant_idx), 32'd0);
        chk("t6_rdy", 32'(bus.req_rdy), 32'd0);
        chk("t6_to", 32'(bus.timeout_pulse), 32'd0);
        bus.req_val = '0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.req_val  = 4'b1000;
        bus.req_data[31:24] = 8'h88;
        bus.req_last = 4'b1000;
        tick();
        chk("t6_g3", 32'(bus.grant_idx), 32'd3);
        chk("t6_gv", 32'(bus.grant_val), 32'd1);
        tick();
        bus.req_val  = '0;
        bus.req_last = '0;
        chk("t6_txdata2", 32'(bus.tx_data), 32'h88);
        chk("t6_txval2", 32'(bus.tx_data_val), 32'd1);
        chk("t6_gdrop", 32'(bus.grant_val), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
